// File: rtl/eth_frame_rr_arb.sv
// Round-robin arbiter granting whole Ethernet frames (header + payload) from S_COUNT sources.
// Optional stalled-payload abort path is enabled by defining ETH_ARB_TIMEOUT_EN.
module eth_frame_rr_arb #(
    parameter int S_COUNT    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024,
    localparam int IW        = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT-1:0]            s_eth_hdr_valid,
    output logic [S_COUNT-1:0]            s_eth_hdr_ready,
    input  logic [S_COUNT*48-1:0]         s_eth_dest_mac,
    input  logic [S_COUNT*48-1:0]         s_eth_src_mac,
    input  logic [S_COUNT*16-1:0]         s_eth_type,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic [S_COUNT-1:0]            s_eth_payload_axis_tvalid,
    input  logic [S_COUNT-1:0]            s_eth_payload_axis_tlast,
    input  logic [S_COUNT-1:0]            s_eth_payload_axis_tuser,
    output logic [S_COUNT-1:0]            s_eth_payload_axis_tready,
    output logic                          m_eth_hdr_valid,
    input  logic                          m_eth_hdr_ready,
    output logic [47:0]                   m_eth_dest_mac,
    output logic [47:0]                   m_eth_src_mac,
    output logic [15:0]                   m_eth_type,
    output logic [DATA_WIDTH-1:0]         m_eth_payload_axis_tdata,
    output logic                          m_eth_payload_axis_tvalid,
    output logic                          m_eth_payload_axis_tlast,
    output logic                          m_eth_payload_axis_tuser,
    input  logic                          m_eth_payload_axis_tready,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_index,
    output logic [2:0]                    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Valid never waits on ready; header ready is combinational on header valid in IDLE.
`ifdef ETH_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_PAYLOAD = 3'd2, ST_ABORT = 3'd3, ST_DRAIN = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_HDR = 3'd1, ST_PAYLOAD = 3'd2
    } state_t;
`endif

    localparam int CW = IW + 1;
    localparam logic [CW-1:0] S_CNT_W  = CW'(S_COUNT);
    localparam logic [IW-1:0] LAST_IDX = IW'(S_COUNT - 1);

    if (S_COUNT < 2 || S_COUNT > 8 || TIMEOUT < 1) begin : g_param_check
        $error("eth_frame_rr_arb: unsupported S_COUNT or TIMEOUT");
    end

    state_t state, state_next;
    logic [IW-1:0] ptr;
    logic [CW-1:0] cand;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic [S_COUNT-1:0] grant_oh;
    logic          g_tvalid, g_tlast, g_tuser;
    logic [DATA_WIDTH-1:0] g_tdata;
    logic [S_COUNT-1:0]    hdr_ready_c, tready_c;
    logic [DATA_WIDTH-1:0] m_tdata_c;
    logic                  m_tvalid_c, m_tlast_c, m_tuser_c;

    // Rotating search: first requester at or above the pointer, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < S_COUNT; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= S_CNT_W) cand = cand - S_CNT_W;
            if (!win_found && s_eth_hdr_valid[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    assign grant_oh = {{(S_COUNT-1){1'b0}}, 1'b1} << grant_index;
    assign g_tvalid = s_eth_payload_axis_tvalid[grant_index];
    assign g_tlast  = s_eth_payload_axis_tlast[grant_index];
    assign g_tuser  = s_eth_payload_axis_tuser[grant_index];
    assign g_tdata  = s_eth_payload_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];

`ifdef ETH_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    assign to_hit = (to_cnt == TW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_next  = state;
        hdr_ready_c = '0;
        tready_c    = '0;
        m_tdata_c   = '0;
        m_tvalid_c  = 1'b0;
        m_tlast_c   = 1'b0;
        m_tuser_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    hdr_ready_c = {{(S_COUNT-1){1'b0}}, 1'b1} << win_idx;
                    state_next  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (m_eth_hdr_ready) state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                m_tdata_c  = g_tdata;
                m_tvalid_c = g_tvalid;
                m_tlast_c  = g_tlast;
                m_tuser_c  = g_tuser;
                tready_c   = m_eth_payload_axis_tready ? grant_oh : '0;
                if (g_tvalid && g_tlast && m_eth_payload_axis_tready) state_next = ST_IDLE;
`ifdef ETH_ARB_TIMEOUT_EN
                else if (!g_tvalid && to_hit) state_next = ST_ABORT;
`endif
            end
`ifdef ETH_ARB_TIMEOUT_EN
            // Close the downstream frame as errored, then swallow the rest of the source frame.
            ST_ABORT: begin
                m_tvalid_c = 1'b1;
                m_tlast_c  = 1'b1;
                m_tuser_c  = 1'b1;
                if (m_eth_payload_axis_tready)
                    state_next = (g_tvalid && g_tlast) ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                tready_c = grant_oh;
                if (g_tvalid && g_tlast) state_next = ST_IDLE;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset must silence combinational outputs immediately, not at the next edge.
    assign s_eth_hdr_ready           = rst ? '0 : hdr_ready_c;
    assign s_eth_payload_axis_tready = rst ? '0 : tready_c;
    assign m_eth_payload_axis_tdata  = rst ? '0 : m_tdata_c;
    assign m_eth_payload_axis_tvalid = m_tvalid_c & ~rst;
    assign m_eth_payload_axis_tlast  = m_tlast_c & ~rst;
    assign m_eth_payload_axis_tuser  = m_tuser_c & ~rst;
    assign dbg_state                 = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            grant_index     <= '0;
            grant_valid     <= 1'b0;
            m_eth_hdr_valid <= 1'b0;
            m_eth_dest_mac  <= '0;
            m_eth_src_mac   <= '0;
            m_eth_type      <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && win_found) begin
                m_eth_dest_mac  <= s_eth_dest_mac[win_idx*48 +: 48];
                m_eth_src_mac   <= s_eth_src_mac[win_idx*48 +: 48];
                m_eth_type      <= s_eth_type[win_idx*16 +: 16];
                m_eth_hdr_valid <= 1'b1;
                grant_index     <= win_idx;
                grant_valid     <= 1'b1;
                ptr             <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            end
            if (state == ST_HDR && m_eth_hdr_ready) m_eth_hdr_valid <= 1'b0;
            if (state != ST_IDLE && state_next == ST_IDLE) grant_valid <= 1'b0;
        end
    end

`ifdef ETH_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state != ST_PAYLOAD) begin
            to_cnt <= '0;
        end else if (g_tvalid) begin
            if (m_eth_payload_axis_tready) to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_frame_rr_arb.sv
// Directed bench for eth_frame_rr_arb with S_COUNT=3: frame table, header/payload stalls,
// async reset mid-frame, and stalled-source behaviour with or without ETH_ARB_TIMEOUT_EN.
module tb_eth_frame_rr_arb;

    localparam int S  = 3;
    localparam int DW = 8;
    localparam int TO = 16;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [S-1:0]      s_eth_hdr_valid;
    logic [S-1:0]      s_eth_hdr_ready;
    logic [S*48-1:0]   s_eth_dest_mac;
    logic [S*48-1:0]   s_eth_src_mac;
    logic [S*16-1:0]   s_eth_type;
    logic [S*DW-1:0]   s_tdata;
    logic [S-1:0]      s_tvalid, s_tlast, s_tuser, s_tready;
    logic              m_eth_hdr_valid, m_eth_hdr_ready;
    logic [47:0]       m_eth_dest_mac, m_eth_src_mac;
    logic [15:0]       m_eth_type;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid, m_tlast, m_tuser, m_tready;
    logic              grant_valid;
    logic [IW-1:0]     grant_index;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [2:0] mask;
        int         win;
        int         nbeats;
        logic [7:0] base;
        logic       tuser_last;
    } vec_t;
    vec_t tbl[10];

    eth_frame_rr_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
        .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
        .s_eth_payload_axis_tdata(s_tdata), .s_eth_payload_axis_tvalid(s_tvalid),
        .s_eth_payload_axis_tlast(s_tlast), .s_eth_payload_axis_tuser(s_tuser),
        .s_eth_payload_axis_tready(s_tready),
        .m_eth_hdr_valid(m_eth_hdr_valid), .m_eth_hdr_ready(m_eth_hdr_ready),
        .m_eth_dest_mac(m_eth_dest_mac), .m_eth_src_mac(m_eth_src_mac), .m_eth_type(m_eth_type),
        .m_eth_payload_axis_tdata(m_tdata), .m_eth_payload_axis_tvalid(m_tvalid),
        .m_eth_payload_axis_tlast(m_tlast), .m_eth_payload_axis_tuser(m_tuser),
        .m_eth_payload_axis_tready(m_tready),
        .grant_valid(grant_valid), .grant_index(grant_index), .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [47:0] dest_of(input int i);
        return {40'h02_0000_0000, i[7:0]};
    endfunction
    function automatic logic [47:0] src_of(input int i);
        return {40'h0A_0000_0000, 8'h10 + i[7:0]};
    endfunction
    function automatic logic [15:0] type_of(input int i);
        return 16'h88B4 + i[15:0];
    endfunction
    function automatic logic [2:0] oh(input int i);
        logic [2:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_beat();
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        s_tdata  = '0;
    endtask

    task automatic set_beat(input int p, input logic [7:0] d, input logic l, input logic u);
        clear_beat();
        s_tvalid[p] = 1'b1;
        s_tlast[p]  = l;
        s_tuser[p]  = u;
        s_tdata[p*DW +: DW] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept header of expected winner, then pass its header through immediately
    task automatic take_header(input logic [2:0] mask, input int win);
        s_eth_hdr_valid = mask;
        @(negedge clk);
        chk("hdr_ready_idle", s_eth_hdr_ready, oh(win));
        chk("grant_valid_idle", grant_valid, 1'b0);
        chk("m_tvalid_idle", m_tvalid, 1'b0);
        step();
        s_eth_hdr_valid = '0;
        @(negedge clk);
        chk("m_hdr_valid", m_eth_hdr_valid, 1'b1);
        chk("grant", {grant_valid, grant_index}, {1'b1, 2'(win)});
        chk("m_hdr_fields", {m_eth_dest_mac, m_eth_type}, {dest_of(win), type_of(win)});
        chk("m_src_mac", m_eth_src_mac, src_of(win));
        chk("s_tready_hdr", s_tready, 3'b000);
        m_eth_hdr_ready = 1'b1;
        step();
        m_eth_hdr_ready = 1'b0;
    endtask

    // One forwarded beat with m tready=1, checked through the scoreboard
    task automatic fwd_beat(input int win, input logic [7:0] d, input logic l, input logic u);
        logic [9:0] w;
        m_tready = 1'b1;
        set_beat(win, d, l, u);
        exp_q.push_back({u, l, d});
        @(negedge clk);
        w = exp_q.pop_front();
        chk("m_beat", {m_tvalid, m_tuser, m_tlast, m_tdata}, {1'b1, w});
        chk("s_tready_beat", s_tready, oh(win));
        chk("m_hdr_valid_payload", m_eth_hdr_valid, 1'b0);
        step();
    endtask

    task automatic send_frame(input vec_t v);
        take_header(v.mask, v.win);
        for (int b = 0; b < v.nbeats; b++)
            fwd_beat(v.win, v.base + 8'(b), b == v.nbeats - 1, v.tuser_last && (b == v.nbeats - 1));
        clear_beat();
    endtask

    initial begin
        // Expected winners hand-derived from pointer=0 after reset
        tbl[0] = '{3'b111, 0, 2, 8'h10, 1'b0};
        tbl[1] = '{3'b111, 1, 3, 8'h20, 1'b0};
        tbl[2] = '{3'b111, 2, 1, 8'h30, 1'b0};
        tbl[3] = '{3'b111, 0, 2, 8'h40, 1'b0};
        tbl[4] = '{3'b010, 1, 4, 8'hA0, 1'b0};
        tbl[5] = '{3'b011, 0, 2, 8'h50, 1'b0};
        tbl[6] = '{3'b101, 2, 3, 8'h60, 1'b1};
        tbl[7] = '{3'b110, 1, 1, 8'h70, 1'b1};
        tbl[8] = '{3'b001, 0, 2, 8'h80, 1'b0};
        tbl[9] = '{3'b100, 2, 2, 8'h90, 1'b0};

        rst = 1'b1;
        m_eth_hdr_ready = 1'b0;
        m_tready = 1'b0;
        clear_beat();
        for (int i = 0; i < S; i++) begin
            s_eth_dest_mac[i*48 +: 48] = dest_of(i);
            s_eth_src_mac[i*48 +: 48]  = src_of(i);
            s_eth_type[i*16 +: 16]     = type_of(i);
        end
        s_eth_hdr_valid = 3'b111;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hdr_ready", s_eth_hdr_ready, 3'b000);
        chk("rst_m_hdr", {m_eth_hdr_valid, m_eth_dest_mac, m_eth_type}, 65'd0);
        chk("rst_grant", {grant_valid, grant_index}, 3'b000);
        chk("rst_m_payload", {m_tvalid, m_tlast, m_tuser}, 3'b000);
        s_eth_hdr_valid = '0;
        step();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) send_frame(tbl[i]);

        // Header held 5 cycles, then payload with m tready toggling
        s_eth_hdr_valid = 3'b001;
        step();
        s_eth_hdr_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hdr_hold_valid", m_eth_hdr_valid, 1'b1);
            chk("hdr_hold_fields", {m_eth_dest_mac, m_eth_type}, {dest_of(0), type_of(0)});
            chk("hdr_hold_tready", s_tready, 3'b000);
            step();
        end
        m_eth_hdr_ready = 1'b1;
        step();
        m_eth_hdr_ready = 1'b0;
        begin
            int b;
            logic [4:0] pat;
            logic [9:0] w;
            b = 0;
            pat = 5'b10101;
            for (int c = 0; c < 5; c++) begin
                m_tready = pat[c];
                set_beat(0, 8'hC0 + 8'(b), b == 2, 1'b0);
                exp_q.push_back({1'b0, b == 2, 8'hC0 + 8'(b)});
                @(negedge clk);
                chk("toggle_s_tready", s_tready, m_tready ? 3'b001 : 3'b000);
                if (m_tready) w = exp_q.pop_front();
                else w = exp_q.pop_back();
                chk("toggle_m_beat", {m_tvalid, m_tlast, m_tdata}, {1'b1, w[8:0]});
                step();
                if (pat[c]) b++;
            end
            chk("toggle_beats_taken", 32'(b), 32'd3);
        end
        clear_beat();
        m_tready = 1'b1;

        // Async reset mid-payload, between clock edges
        take_header(3'b100, 2);
        fwd_beat(2, 8'hD0, 1'b0, 1'b0);
        set_beat(2, 8'hD1, 1'b0, 1'b0);
        s_eth_hdr_valid = 3'b011;
        #2;
        chk("pre_rst_tvalid", {m_tvalid, s_tready}, {1'b1, 3'b100});
        rst = 1'b1;
        #1;
        chk("async_rst_payload", {m_tvalid, m_tlast, s_tready}, 5'b0);
        chk("async_rst_hdr", {m_eth_hdr_valid, s_eth_hdr_ready}, 4'b0);
        chk("async_rst_grant", {grant_valid, grant_index}, 3'b000);
        step();
        rst = 1'b0;
        clear_beat();
        send_frame('{3'b011, 0, 2, 8'hE0, 1'b0});

        // Source 1 stalls after 3 beats while source 2 waits
        take_header(3'b010, 1);
        for (int b = 0; b < 3; b++) fwd_beat(1, 8'hF0 + 8'(b), 1'b0, 1'b0);
        clear_beat();
        s_eth_hdr_valid = 3'b100;
`ifdef ETH_ARB_TIMEOUT_EN
        for (int c = 0; c < TO; c++) begin
            @(negedge clk);
            chk("stall_no_beat", {m_tvalid, s_eth_hdr_ready}, 4'b0);
            step();
        end
        @(negedge clk);
        chk("abort_beat", {m_tvalid, m_tuser, m_tlast, m_tdata}, {3'b111, 8'h00});
        chk("abort_s_tready", s_tready, 3'b000);
        step();
        for (int b = 0; b < 5; b++) begin
            set_beat(1, 8'hF3 + 8'(b), b == 4, 1'b0);
            @(negedge clk);
            chk("drain_s_tready", s_tready, 3'b010);
            chk("drain_no_fwd", {m_tvalid, s_eth_hdr_ready}, 4'b0);
            step();
        end
`else
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_no_beat", {m_tvalid, s_eth_hdr_ready}, 4'b0);
            chk("stall_grant_held", {grant_valid, grant_index}, 3'b101);
            step();
        end
        for (int b = 0; b < 5; b++) fwd_beat(1, 8'hF3 + 8'(b), b == 4, 1'b0);
`endif
        clear_beat();
        send_frame('{3'b100, 2, 2, 8'h55, 1'b1});

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
